spdif_channel_status_sequencer: RTL and testbench

- Sequences the 192-bit consumer Channel Status word out one bit per subframe to the S/PDIF subframe encoder.
- Tracks frame position within the 192-frame block and flags block start, which drives the "B" preamble or the HDMI "B" bit.
- Double-buffers the configuration so that new settings take effect only at a block boundary.
- Sits between the control/register interface and the subframe encoder. Instantiates the channel-status layout module once per channel.

---
 rtl/spdif_pkg.sv | 45 ++++
 rtl/spdif_channel_status.sv | 31 +++
 rtl/spdif_channel_status_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_spdif_channel_status_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// spdif_pkg
// Shared constants and types for the S/PDIF consumer channel-status path.
//   - Block length (frames per channel-status block) and word size.
//   - Sampling-frequency, word-length and category code constants. All
//     multi-bit fields are placed LSB-first in the channel-status word,
//     i.e. field bit 0 sits at the lowest channel-status bit index.
//   - Subframe type and expected-subframe state enums.
//   - Configuration record shared by the sequencer and its layout instances.
package spdif_pkg;

    localparam int BLOCK_FRAMES_DEFAULT = 32'd192;
    localparam int CS_BITS              = 32'd192;

    // Sampling-frequency codes (channel-status bits 24..27)
    localparam logic [3:0] FS_44K1 = 4'd0;
    localparam logic [3:0] FS_48K  = 4'd2;

    // Word-length codes (channel-status bits 32..35)
    localparam logic [3:0] WL_NONE = 4'd0;
    localparam logic [3:0] WL_16   = 4'd2;

    // Category codes (channel-status bits 8..15, bit 8 = LSB)
    localparam logic [7:0] CAT_GENERAL      = 8'b00000000;
    localparam logic [7:0] CAT_DVD          = 8'b10011001;
    localparam logic [7:0] CAT_EXPERIMENTAL = 8'b10000000;

    typedef enum logic {
        SUB_A = 1'b0,
        SUB_B = 1'b1
    } subframe_e;

    typedef enum logic {
        EXP_A = 1'b0,
        EXP_B = 1'b1
    } expect_e;

    typedef struct packed {
        logic [7:0] category;
        logic [3:0] sampling_freq;
        logic [3:0] word_length;
        logic [3:0] chan_a;
        logic [3:0] chan_b;
    } cs_cfg_t;

endpackage

// File: rtl/spdif_channel_status.sv
// spdif_channel_status
// Builds the 192-bit consumer channel-status word from its fields.
// Ports:
//   category      in  8   category code, bits 8..15
//   sampling_freq in  4   sampling frequency, bits 24..27 (inverted copy in 36..39)
//   word_length   in  4   word length, bits 32..35
//   channel_num   in  4   channel number, bits 20..23
//   word          out 192 channel-status word, index = frame number
// Bits 0..7 (consumer, PCM, no emphasis, mode 0), source number, clock
// accuracy and all bits above 39 are zero.
module spdif_channel_status
    import spdif_pkg::*;
(
    input  logic [7:0]         category,
    input  logic [3:0]         sampling_freq,
    input  logic [3:0]         word_length,
    input  logic [3:0]         channel_num,
    output logic [CS_BITS-1:0] word
);

    // Place each field LSB-first at its channel-status position
    always_comb begin
        word        = {CS_BITS{1'b0}};
        word[15:8]  = category;
        word[23:20] = channel_num;
        word[27:24] = sampling_freq;
        word[35:32] = word_length;
        word[39:36] = ~sampling_freq;
    end

endmodule

// File: rtl/spdif_channel_status_sequencer.sv
// spdif_channel_status_sequencer
// Serves the consumer channel-status C bit one subframe at a time, tracks the
// frame position inside the block and double-buffers the configuration so a
// new setting only takes effect at a block boundary (or while disabled).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enable              0 = hold frame index at 0 and ignore requests
//   cfgValid/cfgReady   configuration offer handshake
//   cfg*                offered category, fs, word length, channel numbers
//   subframeReq/IsB     C-bit request and requested subframe (A/B)
//   statusValid         one-cycle response pulse, one cycle after the request
//   statusBit           C bit for the requested subframe
//   blockStart          the served subframe belongs to frame 0
//   frameIndex          current frame index
//   orderError          one-cycle pulse on an out-of-order request
module spdif_channel_status_sequencer
    import spdif_pkg::*;
#(
    parameter int         BLOCK_FRAMES        = BLOCK_FRAMES_DEFAULT,
    parameter logic [7:0] RESET_CATEGORY      = CAT_GENERAL,
    parameter logic [3:0] RESET_SAMPLING_FREQ = FS_48K,
    parameter logic [3:0] RESET_WORD_LENGTH   = WL_16,
    localparam int        IDX_W               = $clog2(BLOCK_FRAMES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfgValid,
    output logic             cfgReady,
    input  logic [7:0]       cfgCategoryCode,
    input  logic [3:0]       cfgSamplingFreq,
    input  logic [3:0]       cfgWordLength,
    input  logic [3:0]       cfgChannelNumA,
    input  logic [3:0]       cfgChannelNumB,
    input  logic             subframeReq,
    input  logic             subframeIsB,
    output logic             statusValid,
    output logic             statusBit,
    output logic             blockStart,
    output logic [IDX_W-1:0] frameIndex,
    output logic             orderError
);

    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_IDX  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_FRAMES - 1);
    localparam cs_cfg_t RESET_CFG = '{
        category:      RESET_CATEGORY,
        sampling_freq: RESET_SAMPLING_FREQ,
        word_length:   RESET_WORD_LENGTH,
        chan_a:        4'd0,
        chan_b:        4'd0
    };

    cs_cfg_t            active_r;
    cs_cfg_t            pending_r;
    logic               cfg_ready_r;
    expect_e            expect_r;
    logic [IDX_W-1:0]   frame_r;
    logic               status_valid_r;
    logic               status_bit_r;
    logic               block_start_r;
    logic               order_error_r;

    cs_cfg_t            layout_cfg_s;
    logic [CS_BITS-1:0] word_a_s;
    logic [CS_BITS-1:0] word_b_s;
    logic               req_s;
    logic               is_b_s;
    logic               last_frame_s;
    logic [IDX_W-1:0]   frame_inc_s;
    logic [IDX_W-1:0]   frame_next_s;
    logic [IDX_W-1:0]   serve_idx_s;
    logic               misorder_s;
    logic               advance_s;
    logic               early_wrap_s;
    logic               wrap_s;
    logic               apply_s;
    logic               xfer_s;
    logic               serve_bit_s;
    expect_e            expect_next_s;

    assign cfgReady    = cfg_ready_r;
    assign statusValid = status_valid_r;
    assign statusBit   = status_bit_r;
    assign blockStart  = block_start_r;
    assign frameIndex  = frame_r;
    assign orderError  = order_error_r;

    spdif_channel_status u_layout_a (
        .category      (layout_cfg_s.category),
        .sampling_freq (layout_cfg_s.sampling_freq),
        .word_length   (layout_cfg_s.word_length),
        .channel_num   (layout_cfg_s.chan_a),
        .word          (word_a_s)
    );

    spdif_channel_status u_layout_b (
        .category      (layout_cfg_s.category),
        .sampling_freq (layout_cfg_s.sampling_freq),
        .word_length   (layout_cfg_s.word_length),
        .channel_num   (layout_cfg_s.chan_b),
        .word          (word_b_s)
    );

    // Request decode: frame advance, served index, ordering and config apply
    always_comb begin
        req_s         = subframeReq && enable;
        is_b_s        = (subframe_e'(subframeIsB) == SUB_B);
        last_frame_s  = (frame_r == LAST_IDX);
        frame_inc_s   = last_frame_s ? ZERO_IDX : (frame_r + ONE_IDX);
        misorder_s    = 1'b0;
        advance_s     = 1'b0;
        early_wrap_s  = 1'b0;
        serve_idx_s   = frame_r;
        expect_next_s = expect_r;
        if (req_s) begin
            case (expect_r)
                EXP_A: begin
                    if (is_b_s) begin
                        // A missing: serve B here, close the frame
                        misorder_s    = 1'b1;
                        advance_s     = 1'b1;
                        expect_next_s = EXP_A;
                    end else begin
                        expect_next_s = EXP_B;
                    end
                end
                EXP_B: begin
                    if (is_b_s) begin
                        advance_s     = 1'b1;
                        expect_next_s = EXP_A;
                    end else begin
                        // B missing: close the old frame first, serve A in the new one
                        misorder_s    = 1'b1;
                        advance_s     = 1'b1;
                        serve_idx_s   = frame_inc_s;
                        early_wrap_s  = last_frame_s;
                        expect_next_s = EXP_B;
                    end
                end
                default: begin
                    expect_next_s = EXP_A;
                end
            endcase
        end else begin
            expect_next_s = expect_r;
        end
        frame_next_s = advance_s ? frame_inc_s : frame_r;
        wrap_s       = advance_s && last_frame_s;
        apply_s      = !cfg_ready_r && (wrap_s || !enable);
        xfer_s       = cfgValid && cfg_ready_r;
        // A frame-0 A served in the same cycle as the wrap must already see the new config
        if (early_wrap_s && !cfg_ready_r) begin
            layout_cfg_s = pending_r;
        end else begin
            layout_cfg_s = active_r;
        end
        serve_bit_s = is_b_s ? word_b_s[serve_idx_s] : word_a_s[serve_idx_s];
    end

    // Sequencer state, config double buffer and registered responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r       <= RESET_CFG;
            pending_r      <= RESET_CFG;
            cfg_ready_r    <= 1'b1;
            expect_r       <= EXP_A;
            frame_r        <= ZERO_IDX;
            status_valid_r <= 1'b0;
            status_bit_r   <= 1'b0;
            block_start_r  <= 1'b0;
            order_error_r  <= 1'b0;
        end else begin
            status_valid_r <= req_s;
            status_bit_r   <= req_s && serve_bit_s;
            block_start_r  <= req_s && (serve_idx_s == ZERO_IDX);
            order_error_r  <= req_s && misorder_s;
            if (!enable) begin
                frame_r  <= ZERO_IDX;
                expect_r <= EXP_A;
            end else begin
                frame_r  <= frame_next_s;
                expect_r <= expect_next_s;
            end
            // apply and transfer are exclusive: a transfer needs an empty slot
            if (apply_s) begin
                active_r    <= pending_r;
                cfg_ready_r <= 1'b1;
            end else if (xfer_s) begin
                pending_r   <= '{
                    category:      cfgCategoryCode,
                    sampling_freq: cfgSamplingFreq,
                    word_length:   cfgWordLength,
                    chan_a:        cfgChannelNumA,
                    chan_b:        cfgChannelNumB
                };
                cfg_ready_r <= 1'b0;
            end else begin
                cfg_ready_r <= cfg_ready_r;
            end
        end
    end

endmodule

// File: tb/tb_spdif_channel_status_sequencer.sv
// tb_spdif_channel_status_sequencer
// Scoreboard bench: the driver applies one stimulus per cycle, advances a
// frame/field-level reference model and queues the expected response; an
// independent monitor pops and compares whenever statusValid is seen.
module tb_spdif_channel_status_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       cfgValid = 1'b0;
    logic       cfgReady;
    logic [7:0] cfgCategoryCode = 8'd0;
    logic [3:0] cfgSamplingFreq = 4'd0;
    logic [3:0] cfgWordLength = 4'd0;
    logic [3:0] cfgChannelNumA = 4'd0;
    logic [3:0] cfgChannelNumB = 4'd0;
    logic       subframeReq = 1'b0;
    logic       subframeIsB = 1'b0;
    logic       statusValid;
    logic       statusBit;
    logic       blockStart;
    logic [7:0] frameIndex;
    logic       orderError;

    spdif_channel_status_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .cfgValid        (cfgValid),
        .cfgReady        (cfgReady),
        .cfgCategoryCode (cfgCategoryCode),
        .cfgSamplingFreq (cfgSamplingFreq),
        .cfgWordLength   (cfgWordLength),
        .cfgChannelNumA  (cfgChannelNumA),
        .cfgChannelNumB  (cfgChannelNumB),
        .subframeReq     (subframeReq),
        .subframeIsB     (subframeIsB),
        .statusValid     (statusValid),
        .statusBit       (statusBit),
        .blockStart      (blockStart),
        .frameIndex      (frameIndex),
        .orderError      (orderError)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cat;
        logic [3:0] fs;
        logic [3:0] wl;
        logic [3:0] ca;
        logic [3:0] cb;
    } mcfg_t;

    typedef struct {
        int   due;
        logic bitv;
        logic bstart;
        logic oerr;
    } exp_t;

    localparam int    FRAMES    = 192;
    localparam mcfg_t RESET_CFG = '{cat: 8'h00, fs: 4'd2, wl: 4'd2, ca: 4'd0, cb: 4'd0};

    exp_t  sb_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    mcfg_t m_active = RESET_CFG;
    mcfg_t m_pending = RESET_CFG;
    bit    m_pend_valid = 1'b0;
    int    m_frame = 0;
    bit    m_exp_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Channel-status bit by position, straight from the field map
    function automatic logic cs_bit(input mcfg_t c, input bit b_side, input int idx);
        logic [3:0] ch;
        ch = b_side ? c.cb : c.ca;
        if (idx >= 8 && idx <= 15)       return c.cat[idx-8];
        else if (idx >= 20 && idx <= 23) return ch[idx-20];
        else if (idx >= 24 && idx <= 27) return c.fs[idx-24];
        else if (idx >= 32 && idx <= 35) return c.wl[idx-32];
        else if (idx >= 36 && idx <= 39) return ~c.fs[idx-36];
        else                             return 1'b0;
    endfunction

    task automatic model_advance();
        m_frame = (m_frame + 1) % FRAMES;
        if (m_frame == 0 && m_pend_valid) begin
            m_active     = m_pending;
            m_pend_valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_active     = RESET_CFG;
        m_pending    = RESET_CFG;
        m_pend_valid = 1'b0;
        m_frame      = 0;
        m_exp_b      = 1'b0;
    endtask

    // One clock of stimulus: check state, drive inputs, step the model
    task automatic step(input bit en, input bit req, input bit isb, input bit cv, input mcfg_t nc);
        exp_t e;
        bit   xfer;
        int   idx;
        @(negedge clk);
        check("frameIndex", frameIndex, m_frame);
        check("cfgReady", cfgReady, !m_pend_valid);
        enable          = en;
        subframeReq     = req;
        subframeIsB     = isb;
        cfgValid        = cv;
        cfgCategoryCode = nc.cat;
        cfgSamplingFreq = nc.fs;
        cfgWordLength   = nc.wl;
        cfgChannelNumA  = nc.ca;
        cfgChannelNumB  = nc.cb;
        xfer = cv && !m_pend_valid;
        if (!en) begin
            m_frame = 0;
            m_exp_b = 1'b0;
            if (m_pend_valid) begin
                m_active     = m_pending;
                m_pend_valid = 1'b0;
            end
        end else if (req) begin
            e.oerr = 1'b0;
            if (!isb) begin
                if (m_exp_b) begin
                    e.oerr = 1'b1;
                    model_advance();
                end
                idx     = m_frame;
                e.bitv  = cs_bit(m_active, 1'b0, idx);
                m_exp_b = 1'b1;
            end else begin
                e.oerr = !m_exp_b;
                idx    = m_frame;
                e.bitv = cs_bit(m_active, 1'b1, idx);
                model_advance();
                m_exp_b = 1'b0;
            end
            e.due    = cyc + 1;
            e.bstart = (idx == 0);
            sb_q.push_back(e);
        end
        if (xfer) begin
            m_pending    = nc;
            m_pend_valid = 1'b1;
        end
    endtask

    // Monitor: compare each response against the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset !== 1'b1) begin
            if (statusValid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_statusValid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_cycle", cyc, e.due);
                    check("statusBit", statusBit, e.bitv);
                    check("blockStart", blockStart, e.bstart);
                    check("orderError", orderError, e.oerr);
                end
            end else begin
                check("orderError_idle", orderError, 32'd0);
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    void'(sb_q.pop_front());
                    check("missing_statusValid", 32'd0, 32'd1);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_statusValid"}, statusValid, 32'd0);
        check({tag, "_statusBit"}, statusBit, 32'd0);
        check({tag, "_blockStart"}, blockStart, 32'd0);
        check({tag, "_orderError"}, orderError, 32'd0);
        check({tag, "_frameIndex"}, frameIndex, 32'd0);
        check({tag, "_cfgReady"}, cfgReady, 32'd1);
    endtask

    // Correctly ordered A/B requests until the model reaches frame target
    task automatic run_to(input int target);
        for (int k = 0; k < 1000; k++) begin
            if (m_frame == target && !m_exp_b) break;
            step(1'b1, 1'b1, m_exp_b, 1'b0, RESET_CFG);
        end
    endtask

    initial begin
        mcfg_t nc;
        bit    en;
        bit    req;
        bit    isb;
        bit    cv;

        // Reset with default configuration
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        model_reset();

        // One full block of ordered A/B requests with the reset config
        for (int f = 0; f < FRAMES; f++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, RESET_CFG);
            step(1'b1, 1'b1, 1'b1, 1'b0, RESET_CFG);
        end

        // Channel numbers 1/2 offered at frame 0, take effect at next wrap
        nc = '{cat: 8'h00, fs: 4'd2, wl: 4'd2, ca: 4'd1, cb: 4'd2};
        step(1'b1, 1'b0, 1'b0, 1'b1, nc);
        run_to(0);
        run_to(30);

        // DVD category offered at frame 50, applies at the following wrap
        run_to(50);
        nc = '{cat: 8'b10011001, fs: 4'd2, wl: 4'd2, ca: 4'd1, cb: 4'd2};
        step(1'b1, 1'b0, 1'b0, 1'b1, nc);
        run_to(0);
        run_to(5);

        // A, A then B, B out-of-order sequence
        step(1'b1, 1'b1, 1'b0, 1'b0, RESET_CFG);
        step(1'b1, 1'b1, 1'b0, 1'b0, RESET_CFG);
        step(1'b1, 1'b1, 1'b1, 1'b0, RESET_CFG);
        step(1'b1, 1'b1, 1'b1, 1'b0, RESET_CFG);
        step(1'b1, 1'b0, 1'b0, 1'b0, RESET_CFG);

        // Disable at frame 100 with a request in flight and a config pending
        run_to(95);
        nc = '{cat: 8'b10000000, fs: 4'd0, wl: 4'd0, ca: 4'd3, cb: 4'd4};
        step(1'b1, 1'b0, 1'b0, 1'b1, nc);
        run_to(100);
        step(1'b1, 1'b1, 1'b0, 1'b0, RESET_CFG);
        step(1'b0, 1'b1, 1'b1, 1'b0, RESET_CFG);
        step(1'b0, 1'b1, 1'b0, 1'b0, RESET_CFG);
        run_to(45);

        // Randomized traffic: occasional misorder, config offers, disables
        for (int n = 0; n < 4000; n++) begin
            en  = ($urandom_range(0, 99) > 1);
            req = ($urandom_range(0, 9) < 7);
            isb = m_exp_b ^ ($urandom_range(0, 9) == 0);
            cv  = ($urandom_range(0, 19) == 0);
            nc  = mcfg_t'($urandom);
            step(en, req, isb, cv, nc);
        end

        // Asynchronous reset in the middle of a response
        run_to(60);
        step(1'b1, 1'b1, 1'b0, 1'b0, RESET_CFG);
        @(posedge clk);
        #2;
        reset       = 1'b1;
        subframeReq = 1'b0;
        cfgValid    = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_to(0);
        run_to(45);

        // Drain and confirm every expected response appeared
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, RESET_CFG);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
